// File: rtl/cmd_emit_if.sv
// Descriptor handshake and command-FIFO write port of cmd_emit.
// master: descriptor source / FIFO model side; slave: the encoder.
interface cmd_emit_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op_type;
  logic [3:0]  stride;
  logic [7:0]  kernel;
  logic [7:0]  i_side;
  logic [7:0]  o_side;
  logic [15:0] i_channel;
  logic [15:0] o_channel;
  logic        full;
  logic        wr_en;
  logic [31:0] wr_data;

  modport master (
    output in_valid, op_type, stride, kernel, i_side, o_side, i_channel, o_channel, full,
    input  in_ready, wr_en, wr_data
  );

  modport slave (
    input  in_valid, op_type, stride, kernel, i_side, o_side, i_channel, o_channel, full,
    output in_ready, wr_en, wr_data
  );
endinterface

// File: rtl/cmd_emit.sv
// Layer-descriptor to command-word burst encoder feeding the accelerator command FIFO.
// Define CMD_CHECKSUM_EN to append an XOR checksum word (burst of 4 words instead of 3).
module cmd_emit #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  cmd_emit_if.slave        bus,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] cmd_count
);

`ifdef CMD_CHECKSUM_EN
  localparam int unsigned N = 4;
`else
  localparam int unsigned N = 3;
`endif
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {IDLE, CHECK, PUSH, DONE} state_t;

  state_t state;
  state_t state_nxt;

  logic [2:0]              op_q;
  logic [3:0]              stride_q;
  logic [7:0]              kernel_q;
  logic [7:0]              i_side_q;
  logic [7:0]              o_side_q;
  logic [15:0]             i_ch_q;
  logic [15:0]             o_ch_q;
  logic [7:0]              ksz_q;
  logic [15:0]             s2_q;
  logic [IDX_W-1:0]        idx;
  logic                    in_ready_q;
  logic [WORD_W-1:0]       wr_data_q;
  logic [N-1:0][WORD_W-1:0] words;
  logic                    accept;
  logic                    legal;
  logic                    last;
  logic                    wr_en_c;

  assign accept  = bus.in_valid && in_ready_q;
  assign legal   = ((op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b101)) &&
                   (stride_q != 4'd0) && (kernel_q != 8'd0) && (8'(stride_q) <= kernel_q);
  assign last    = (idx == IDX_W'(N - 1));
  // Write strobe follows full directly so a stalled word is never lost.
  assign wr_en_c = (state == PUSH) && !bus.full;

  assign bus.wr_en    = wr_en_c;
  assign bus.in_ready = in_ready_q;
  assign bus.wr_data  = wr_data_q;

  assign words[0] = {o_side_q, i_side_q, kernel_q, stride_q, 1'b0, op_q};
  assign words[1] = {o_ch_q, i_ch_q};
  assign words[2] = {s2_q, ksz_q, 8'h00};
`ifdef CMD_CHECKSUM_EN
  assign words[3] = words[0] ^ words[1] ^ words[2];
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CHECK;
      CHECK:   state_nxt = legal ? PUSH : IDLE;
      PUSH:    if (wr_en_c && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Descriptor capture, word sequencing and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      stride_q   <= '0;
      kernel_q   <= '0;
      i_side_q   <= '0;
      o_side_q   <= '0;
      i_ch_q     <= '0;
      o_ch_q     <= '0;
      ksz_q      <= '0;
      s2_q       <= '0;
      idx        <= '0;
      in_ready_q <= 1'b1;
      busy       <= 1'b0;
      err        <= 1'b0;
      wr_data_q  <= '0;
      cmd_count  <= '0;
    end else begin
      in_ready_q <= (state_nxt == IDLE);
      busy       <= (state_nxt != IDLE);
      err        <= (state == CHECK) && !legal;

      if (accept) begin
        op_q     <= bus.op_type;
        stride_q <= bus.stride;
        kernel_q <= bus.kernel;
        i_side_q <= bus.i_side;
        o_side_q <= bus.o_side;
        i_ch_q   <= bus.i_channel;
        o_ch_q   <= bus.o_channel;
        ksz_q    <= 8'(bus.kernel * bus.kernel);
        s2_q     <= 16'(bus.kernel) * 16'(bus.stride);
      end

      // wr_data only advances on an actual write, so it holds through full
      if ((state == CHECK) && legal) begin
        idx       <= '0;
        wr_data_q <= words[0];
      end else if (wr_en_c && !last) begin
        idx       <= IDX_W'(idx + 1'b1);
        wr_data_q <= words[IDX_W'(idx + 1'b1)];
      end

      if (state == DONE) cmd_count <= cmd_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cmd_emit.sv
// Self-checking bench for cmd_emit: directed descriptors against a queue-based burst model.
module tb_cmd_emit;

`ifdef CMD_CHECKSUM_EN
  localparam int N = 4;
`else
  localparam int N = 3;
`endif

  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  stride;
    logic [7:0]  kernel;
    logic [7:0]  i_side;
    logic [7:0]  o_side;
    logic [15:0] i_ch;
    logic [15:0] o_ch;
  } desc_t;

  logic       clk;
  logic       rst;
  logic       busy;
  logic       err;
  logic [7:0] cmd_count;

  cmd_emit_if bus ();

  cmd_emit #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .err       (err),
    .cmd_count (cmd_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  function automatic desc_t mk(input int op, input int s, input int k, input int is,
                               input int os, input int ic, input int oc);
    desc_t d;
    d.op = 3'(op); d.stride = 4'(s); d.kernel = 8'(k);
    d.i_side = 8'(is); d.o_side = 8'(os);
    d.i_ch = 16'(ic); d.o_ch = 16'(oc);
    return d;
  endfunction

  function automatic bit is_legal(input desc_t d);
    int s, k;
    s = int'(d.stride);
    k = int'(d.kernel);
    return (d.op == 3'd1 || d.op == 3'd4 || d.op == 3'd5) && s != 0 && k != 0 && s <= k;
  endfunction

  // Command words computed with plain integer arithmetic from the field layout
  function automatic logic [3:0][31:0] enc(input desc_t d);
    logic [3:0][31:0] w;
    int unsigned k, s;
    k = d.kernel;
    s = d.stride;
    w[0] = (32'(d.o_side) << 24) | (32'(d.i_side) << 16) | (32'(d.kernel) << 8) |
           (32'(d.stride) << 4) | 32'(d.op);
    w[1] = (32'(d.o_ch) << 16) | 32'(d.i_ch);
    w[2] = (((k * s) % 65536) << 16) | (((k * k) % 256) << 8);
    w[3] = w[0] ^ w[1] ^ w[2];
    return w;
  endfunction

  // Model state, owned by the monitor
  logic [31:0] exp_q[$];
  logic [7:0]  exp_count = 0;
  int          err_due   = -1;
  int          first_due = -1;
  int          wr_total  = 0;
  int          acc_total = 0;
  int          err_seen  = 0;
  int          last_acc  = 0;
  int          prev_acc  = 0;

  always @(negedge clk) begin
    desc_t d;
    logic [3:0][31:0] w;
    if (rst) begin
      exp_q.delete();
      exp_count = 0;
      err_due   = -1;
      first_due = -1;
    end else begin
      chk("err_pulse", 32'(err), 32'(cyc == err_due));
      if (err) err_seen++;
      chk("busy_vs_ready", 32'(busy), 32'(!bus.in_ready));
      if (bus.in_ready) chk("cmd_count_idle", 32'(cmd_count), 32'(exp_count));
      if (bus.full) chk("wr_en_while_full", 32'(bus.wr_en), 32'd0);
      if (cyc == first_due && !bus.full) chk("first_write_latency", 32'(bus.wr_en), 32'd1);
      if (bus.wr_en) begin
        if (cyc < first_due) chk("write_too_early", 32'(cyc), 32'(first_due));
        if (exp_q.size() == 0) chk("spurious_write", bus.wr_data, 32'hxxxxxxxx);
        else                   chk("wr_data", bus.wr_data, exp_q.pop_front());
        wr_total++;
      end
      if (bus.in_valid && bus.in_ready) begin
        d.op = bus.op_type; d.stride = bus.stride; d.kernel = bus.kernel;
        d.i_side = bus.i_side; d.o_side = bus.o_side;
        d.i_ch = bus.i_channel; d.o_ch = bus.o_channel;
        acc_total++;
        prev_acc = last_acc;
        last_acc = cyc;
        if (is_legal(d)) begin
          w = enc(d);
          for (int j = 0; j < N; j++) exp_q.push_back(w[j]);
          exp_count = exp_count + 8'd1;
          first_due = cyc + 2;
        end else begin
          err_due = cyc + 2;
        end
      end
    end
  end

  task automatic drive(input desc_t d);
    bus.op_type = d.op; bus.stride = d.stride; bus.kernel = d.kernel;
    bus.i_side = d.i_side; bus.o_side = d.o_side;
    bus.i_channel = d.i_ch; bus.o_channel = d.o_ch;
  endtask

  task automatic send(input desc_t d);
    int n;
    @(posedge clk); #1;
    drive(d);
    bus.in_valid = 1'b1;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
    end
    if (n == 50) fail_now("send_accept_timeout");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (bus.in_ready && !busy) break;
      n++;
    end
    if (n == 60) fail_now("idle_timeout");
    @(posedge clk);
  endtask

  task automatic wait_wr(input int target);
    int n;
    n = 0;
    while (wr_total < target && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (wr_total < target) fail_now("write_wait_timeout");
  endtask

  task automatic wait_acc(input int target);
    int n;
    n = 0;
    while (acc_total < target && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (acc_total < target) fail_now("accept_wait_timeout");
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    desc_t conv, pool, trunc, bad;
    logic [3:0][31:0] w;
    int w0, c0, e0;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.full = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0));

    // Reset values
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_wr_data", bus.wr_data, 32'd0);
    chk("rst_cmd_count", 32'(cmd_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Pin the model to hand-computed words
    conv = mk(1, 2, 3, 227, 113, 3, 64);
    w = enc(conv);
    chk("model_w0", w[0], 32'h71E30321);
    chk("model_w1", w[1], 32'h00400003);
    chk("model_w2", w[2], 32'h00060900);
    chk("model_w3", w[3], 32'h71A50A22);
    trunc = mk(5, 3, 20, 64, 21, 16, 16);
    w = enc(trunc);
    chk("model_ksz_trunc", w[2], 32'h003C9000);

    // Conv descriptor, no backpressure
    w0 = wr_total;
    send(conv);
    wait_idle();
    chk("conv_writes", 32'(wr_total - w0), 32'(N));
    chk("conv_cmd_count", 32'(cmd_count), 32'd1);

    // Illegal descriptors: stride > kernel, bad op, zero stride
    for (int t = 0; t < 3; t++) begin
      case (t)
        0:       bad = mk(1, 4, 3, 10, 10, 1, 1);
        1:       bad = mk(2, 1, 3, 10, 10, 1, 1);
        default: bad = mk(4, 0, 3, 10, 10, 1, 1);
      endcase
      w0 = wr_total;
      e0 = err_seen;
      send(bad);
      wait_idle();
      chk("illegal_err_once", 32'(err_seen - e0), 32'd1);
      chk("illegal_no_write", 32'(wr_total - w0), 32'd0);
      chk("illegal_in_ready", 32'(bus.in_ready), 32'd1);
      chk("illegal_cmd_count", 32'(cmd_count), 32'd1);
    end

    // Backpressure while W1 pending
    w0 = wr_total;
    send(conv);
    wait_wr(w0 + 1);
    #1 bus.full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_wr_en_low", 32'(bus.wr_en), 32'd0);
      chk("bp_wr_data_hold", bus.wr_data, 32'h00400003);
    end
    @(posedge clk); #1;
    bus.full = 1'b0;
    wait_idle();
    chk("bp_total_writes", 32'(wr_total - w0), 32'(N));
    chk("bp_cmd_count", 32'(cmd_count), 32'd2);

    // Back-to-back max pool with in_valid held
    pool = mk(4, 2, 2, 56, 28, 64, 64);
    w0 = wr_total;
    c0 = acc_total;
    @(posedge clk); #1;
    drive(pool);
    bus.in_valid = 1'b1;
    wait_acc(c0 + 1);
    @(negedge clk);
    chk("b2b_in_ready_low", 32'(bus.in_ready), 32'd0);
    wait_acc(c0 + 2);
    #1 bus.in_valid = 1'b0;
    wait_idle();
    chk("b2b_writes", 32'(wr_total - w0), 32'(2 * N));
    chk("b2b_period", 32'(last_acc - prev_acc), 32'(N + 3));
    chk("b2b_cmd_count", 32'(cmd_count), 32'd4);

    // Kernel product truncation
    send(trunc);
    wait_idle();
    chk("trunc_cmd_count", 32'(cmd_count), 32'd5);

    // Reset after W0 of a burst
    w0 = wr_total;
    send(conv);
    wait_wr(w0 + 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("mid_rst_wr_data", bus.wr_data, 32'd0);
    chk("mid_rst_cmd_count", 32'(cmd_count), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_rst_no_more_writes", 32'(wr_total - w0), 32'd1);
    send(conv);
    wait_idle();
    chk("post_rst_full_burst", 32'(wr_total - w0), 32'(1 + N));
    chk("post_rst_cmd_count", 32'(cmd_count), 32'd1);

    // 256 legal commands wrap the counter
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      int k, s, op;
      k = 1 + (i % 15);
      s = 1 + ((i * 7) % k);
      case (i % 3)
        0:       op = 1;
        1:       op = 4;
        default: op = 5;
      endcase
      send(mk(op, s, k, i, 255 - i, i * 3, 65535 - i));
      wait_idle();
      if (i == 254) chk("wrap_count_255", 32'(cmd_count), 32'd255);
    end
    chk("wrap_count_0", 32'(cmd_count), 32'd0);
    chk("wrap_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
